// File: rtl/req_arbiter.sv
// req_arbiter: shares one resource among N requesters.
// In IDLE, picks a winner from req and registers a one-hot grant plus its
// index. The grant is held until the owner asserts done, drops its request,
// or the hold timeout expires. Every release passes through IDLE, so there
// is always at least one gnt=0 cycle between two owners.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   req      - level-sensitive request vector, bit i = requester i
//   done     - current owner releases the resource this cycle
//   gnt      - registered one-hot grant
//   gnt_id   - binary index of the current owner (valid when gnt_vld=1)
//   gnt_vld  - a grant is active (OR of gnt)
//   timeout  - one-cycle pulse in the first idle cycle after a forced release
//
// Optional build macro: REQ_ARBITER_ROUND_ROBIN_EN
//   defined   - rotating priority; search starts at last_id-1 and goes down,
//               wrapping from 0 to N-1
//   undefined - fixed priority; the highest set bit of req wins
module req_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDW      = 3,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld,
  output logic           timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic           timeout_q, timeout_d;
  logic [IDW-1:0] win_id;

`ifdef REQ_ARBITER_ROUND_ROBIN_EN
  logic [IDW-1:0] last_id_q, last_id_d;
  logic           found;
  int unsigned    idx;

  // Walk downward from last_id-1; the previous owner is visited last.
  always_comb begin
    win_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last_id_q) + N - i) % N;
      if (!found && req[IDW'(idx)]) begin
        win_id = IDW'(idx);
        found  = 1'b1;
      end
    end
  end
`else
  // Later iterations override earlier ones, so the highest set bit wins.
  always_comb begin
    win_id = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[IDW'(i)]) begin
        win_id = IDW'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`ifdef REQ_ARBITER_ROUND_ROBIN_EN
    last_id_d  = last_id_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d        = GRANT;
          gnt_d          = '0;
          gnt_d[win_id]  = 1'b1;
          gnt_id_d       = win_id;
          hold_cnt_d     = CNT_W'(1);
`ifdef REQ_ARBITER_ROUND_ROBIN_EN
          last_id_d      = win_id;
`endif
        end
      end
      GRANT: begin
        // Normal release is checked first so it masks a coincident timeout.
        if (!req[gnt_id_q] || done) begin
          state_d    = IDLE;
          gnt_d      = '0;
          gnt_id_d   = '0;
          hold_cnt_d = '0;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD))) begin
          state_d    = IDLE;
          gnt_d      = '0;
          gnt_id_d   = '0;
          hold_cnt_d = '0;
          timeout_d  = 1'b1;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q != '1)) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = '0;
        gnt_id_d   = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef REQ_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id_q <= IDW'(N - 1);
    end else begin
      last_id_q <= last_id_d;
    end
  end
`endif

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = |gnt_q;
  assign timeout = timeout_q;

endmodule

// File: doc/req_arbiter.md
Name: req_arbiter

Overview:
- Sequential arbiter sharing one resource (e.g. a bus or shared unit) among N requesters.
- Each cycle in IDLE it picks one winner from a request vector by priority encoding (highest set index wins) and registers a one-hot grant plus its binary index.
- The grant is held until the owner signals done, drops its request, or a hold-timeout expires.
- Sits between requesting agents and the shared resource's select mux.

Parameters:
- N, 8, number of requesters.
- IDW, 3, width of grant index; must equal clog2(N).
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership; 0 disables timeout.
- CNT_W, 5, hold counter width; must hold MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector, bit i = requester i; level-sensitive.
- done  input  1  current owner releases the resource this cycle.
- gnt  output  N  one-hot grant, registered.
- gnt_id  output  IDW  binary index of the current owner; valid when gnt_vld=1.
- gnt_vld  output  1  a grant is active (OR of gnt).
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. While rst_n=0, all outputs are immediately 0: gnt, gnt_id, gnt_vld, timeout. State=IDLE, hold_cnt=0, last_id=N-1.
- Reset asserted mid-grant drops gnt asynchronously. No state survives reset.
- States:
  - IDLE: gnt=0. If req!=0 at a rising edge, go to GRANT. The winner is registered so gnt/gnt_id/gnt_vld assert on the following cycle, giving a latency of 1 clock from the sampled req. hold_cnt loads 1.
  - GRANT: outputs stable. Release conditions are evaluated at each rising edge, in this order:
    1. req[gnt_id]=0 or done=1 → IDLE (normal release).
    2. MAX_HOLD!=0 and hold_cnt==MAX_HOLD → IDLE with timeout=1 for exactly the first cycle in which gnt=0.
    3. Otherwise stay in GRANT and increment hold_cnt.
  - Release and timeout in the same edge: normal release wins; timeout stays 0.
- Every release goes through IDLE. This guarantees at least one gnt=0 cycle between owners (turnaround) and allows no back-to-back grants.
- Winner selection (default): fixed priority; the highest set bit of req wins. Lower requesters can starve.
- last_id updates to the winner on every grant.
- Requests from non-owners during GRANT are ignored. They must stay asserted to be considered at the next IDLE.
- The owner dropping req and raising done in the same cycle is treated as a single release.
- req changing while in IDLE is sampled only at the rising edge. No glitch reaches gnt.
- hold_cnt saturates and never wraps. With MAX_HOLD=0 the counter is frozen and timeout never asserts.
- Invariant: gnt is zero or one-hot. gnt_vld==|gnt. gnt[gnt_id]==1 whenever gnt_vld=1.

Optional Feature:
- Macro: REQ_ARBITER_ROUND_ROBIN_EN.
- Defined: rotating priority. The search starts at index last_id-1 and proceeds downward, wrapping from 0 to N-1. The most recent owner therefore has lowest priority at the next arbitration. After reset, last_id=N-1, so the first search starts at N-2 and N-1 is checked last.
- Undefined: pure fixed priority as above; last_id is unused and may be optimised away.
- Latency, handshake and timeout behaviour are identical in both builds.

Test Plan:
- Reset, then req=8'b01001100 → one cycle later gnt=8'b01000000, gnt_id=6, gnt_vld=1. done=1 → next cycle gnt=0, timeout=0.
- req=8'b00001011 held with done=0, MAX_HOLD=16 → gnt_id=3 for exactly 16 cycles, then gnt=0 with a timeout pulse of 1 cycle. Next cycle re-grants id 3 (fixed build).
- req=8'b00000001, owner drops req after 3 cycles → gnt_id=0 for 3 cycles, then gnt=0, timeout=0, then IDLE with no grant.
- ROUND_ROBIN_EN, req=8'hFF, every grant released by done after 1 cycle → gnt_id sequence 6,5,4,3,2,1,0,7,6 with a gnt=0 cycle between each. Fixed build gives 7,7,7,….
- rst_n pulsed low mid-GRANT (gnt_id=5) → gnt=0 within the same cycle with no clock edge. After release, first grant follows the reset-state rules.
- done=1 and hold_cnt==MAX_HOLD on the same edge → gnt drops, timeout stays 0.
